regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001: Parameter NREG, default 32 — number of architectural registers; x0 included.
REQ-002: Parameter CNTW, default 2 — width of the per-register pending-write counter.
REQ-003: clk  input  1  — single clock; all state updates on the rising edge.
REQ-004: rst_n  input  1  — reset; asynchronous, active-low.
REQ-005: r0num_i  input  5  — decode read port 0 register number (rs1).
REQ-006: r0valid_i  input  1  — read port 0 operand is needed.
REQ-007: r1num_i  input  5  — decode read port 1 register number (rs2).
REQ-008: r1valid_i  input  1  — read port 1 operand is needed.
REQ-009: rdnum_i  input  5  — destination register number from decode.
REQ-010: rdreserve_i  input  1  — decode issues a writer of rdnum_i this cycle.
REQ-011: r0data_o  output  32  — read data for r0num_i, combinational.
REQ-012: r1data_o  output  32  — read data for r1num_i, combinational.
REQ-013: rsreserved_o  output  1  — a needed source is pending; decode must stall.
REQ-014: wb_valid_i  input  1  — writeback request this cycle.
REQ-015: wb_num_i  input  5  — writeback register number.
REQ-016: wb_data_i  input  32  — writeback data.
REQ-017: sb_err_o  output  1  — sticky scoreboard error flag.

Function
REQ-018: Register array regs[1..NREG-1] SHALL be 32 bits each; x0 SHALL read 0 and SHALL never be written or reserved.
REQ-019: Each register n≠0 SHALL have a pending counter cnt[n] of CNTW bits; busy(n) = (cnt[n] != 0).
REQ-020: On a clock edge with wb_valid_i=1 and wb_num_i≠0, regs[wb_num_i] SHALL take wb_data_i.
REQ-021: cnt[n] SHALL be incremented by rdreserve_i & (rdnum_i==n) and decremented by wb_valid_i & (wb_num_i==n); both on the same n SHALL leave cnt[n] unchanged.
REQ-022: Increment of a counter at its maximum value (2^CNTW-1) SHALL leave it saturated and set sb_err_o.
REQ-023: Decrement of a counter already at 0 SHALL leave it at 0 and set sb_err_o.
REQ-024: sb_err_o SHALL stay set until reset.
REQ-025: Read bypass: if wb_valid_i=1 and wb_num_i equals a nonzero read number, that port SHALL return wb_data_i in the same cycle; otherwise it SHALL return regs[num].
REQ-026: Effective pending for source n: eff(n) = cnt[n] − (wb_valid_i & wb_num_i==n); source is blocked iff eff(n) != 0.
REQ-027: rsreserved_o = (r0valid_i & blocked(r0num_i)) | (r1valid_i & blocked(r1num_i)); x0 is never blocked.
REQ-028: rsreserved_o SHALL NOT depend on rdreserve_i or rdnum_i, so that no combinational loop forms through decode.
REQ-029: A writer reserving rd in cycle t SHALL make rd blocked for readers from cycle t+1 onward, until its matching writeback.
REQ-030: Multiple in-flight writers of the same rd SHALL keep the register blocked until the final writeback (WAW-safe via counter).
REQ-031: Read data and rsreserved_o SHALL have zero-cycle latency (pure combinational from inputs and state).

Reset
REQ-032: While rst_n=0, all regs SHALL be 0, all cnt SHALL be 0, and sb_err_o SHALL be 0; rsreserved_o SHALL then be 0.
REQ-033: Reset assertion mid-operation SHALL discard all pending reservations immediately, without waiting for a clock edge.
REQ-034: The first state update after release SHALL occur on the first rising clk with rst_n=1.

Verification
REQ-035: Reset, then write x5=0x12345678 via wb, then read r0num=5 next cycle -> r0data_o=0x12345678, rsreserved_o=0.
REQ-036: rdreserve x7 at t; at t+1 r1num=7, r1valid=1 -> rsreserved_o=1; at t+3 wb x7=0xA5A5A5A5 -> same cycle rsreserved_o=0, r1data_o=0xA5A5A5A5.
REQ-037: Reserve x3 twice (t, t+1); first wb at t+2 -> rsreserved_o stays 1 for reader of x3; second wb at t+4 -> 0.
REQ-038: wb x0=0xFFFFFFFF with rdreserve x0 -> r0data_o for x0 = 0, rsreserved_o=0, sb_err_o=0.
REQ-039: Reserve x9 four times with CNTW=2 -> sb_err_o=1 after the 4th edge; wb x1 with cnt=0 on a fresh reset -> sb_err_o=1.
REQ-040: Reserve x4, assert rst_n=0 between clock edges -> rsreserved_o for x4 drops to 0 before the next edge; regs read 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// Writeback data is forwarded to the read ports, and the stall flag accounts for a same-cycle writeback.
module regfile_sb #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  r0num_i,
  input  logic        r0valid_i,
  input  logic [4:0]  r1num_i,
  input  logic        r1valid_i,
  input  logic [4:0]  rdnum_i,
  input  logic        rdreserve_i,
  output logic [31:0] r0data_o,
  output logic [31:0] r1data_o,
  output logic        rsreserved_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_num_i,
  input  logic [31:0] wb_data_i,
  output logic        sb_err_o
);

  localparam logic [CNTW-1:0] CMAX = '1;
  localparam logic [CNTW-1:0] CONE = 1;

  logic [31:0]     regs [NREG];
  logic [CNTW-1:0] cnt  [NREG];
  logic            sb_err;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  logic [CNTW-1:0] c0, c1;
  logic            hit0, hit1;
  logic            blk0, blk1;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int n = 1; n < NREG; n++) begin
      inc[n] = rdreserve_i && (rdnum_i == 5'(n));
      dec[n] = wb_valid_i && (wb_num_i == 5'(n));
    end
  end

  always_comb begin
    r0data_o = '0;
    if (r0num_i != '0 && int'(r0num_i) < NREG) begin
      if (wb_valid_i && wb_num_i == r0num_i) r0data_o = wb_data_i;
      else                                   r0data_o = regs[r0num_i];
    end
  end

  always_comb begin
    r1data_o = '0;
    if (r1num_i != '0 && int'(r1num_i) < NREG) begin
      if (wb_valid_i && wb_num_i == r1num_i) r1data_o = wb_data_i;
      else                                   r1data_o = regs[r1num_i];
    end
  end

  // A source stays blocked only if pending writers remain after this cycle's writeback.
  always_comb begin
    c0   = '0;
    c1   = '0;
    hit0 = wb_valid_i && (wb_num_i == r0num_i);
    hit1 = wb_valid_i && (wb_num_i == r1num_i);
    if (r0num_i != '0 && int'(r0num_i) < NREG) c0 = cnt[r0num_i];
    if (r1num_i != '0 && int'(r1num_i) < NREG) c1 = cnt[r1num_i];
    blk0 = (c0 > CONE) || (c0 == CONE && !hit0);
    blk1 = (c1 > CONE) || (c1 == CONE && !hit1);
    rsreserved_o = (r0valid_i && blk0) || (r1valid_i && blk1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREG; n++) begin
        regs[n] <= '0;
        cnt[n]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int n = 1; n < NREG; n++) begin
        if (dec[n]) regs[n] <= wb_data_i;
        if (inc[n] && !dec[n]) begin
          if (cnt[n] == CMAX) sb_err <= 1'b1;
          else                cnt[n] <= cnt[n] + CONE;
        end else if (dec[n] && !inc[n]) begin
          if (cnt[n] == '0) sb_err <= 1'b1;
          else              cnt[n] <= cnt[n] - CONE;
        end
      end
    end
  end

  assign sb_err_o = sb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Scenario bench for regfile_sb: each task drives a cycle table and checks
// scoreboarded expectations at the falling edge.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  r0num_i, r1num_i, rdnum_i, wb_num_i;
  logic        r0valid_i, r1valid_i, rdreserve_i, wb_valid_i;
  logic [31:0] wb_data_i, r0data_o, r1data_o;
  logic        rsreserved_o, sb_err_o;

  regfile_sb #(.NREG(32), .CNTW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0num_i(r0num_i), .r0valid_i(r0valid_i),
    .r1num_i(r1num_i), .r1valid_i(r1valid_i),
    .rdnum_i(rdnum_i), .rdreserve_i(rdreserve_i),
    .r0data_o(r0data_o), .r1data_o(r1data_o),
    .rsreserved_o(rsreserved_o),
    .wb_valid_i(wb_valid_i), .wb_num_i(wb_num_i), .wb_data_i(wb_data_i),
    .sb_err_o(sb_err_o)
  );

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rs;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [4:0]  r0n;
    logic        r0v;
    logic [4:0]  r1n;
    logic        r1v;
    logic [4:0]  rdn;
    logic        rdr;
    logic        wbv;
    logic [4:0]  wbn;
    logic [31:0] wbd;
  } stim_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input int rst, input int r0n, input int r0v, input int r1n,
                               input int r1v, input int rdn, input int rdr, input int wbv,
                               input int wbn, input logic [31:0] wbd);
    stim_t s;
    s.rst = 1'(rst); s.r0n = 5'(r0n); s.r0v = 1'(r0v); s.r1n = 5'(r1n); s.r1v = 1'(r1v);
    s.rdn = 5'(rdn); s.rdr = 1'(rdr); s.wbv = 1'(wbv); s.wbn = 5'(wbn); s.wbd = wbd;
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] d0, input logic [31:0] d1, input int rs, input int err);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.rs = 1'(rs); e.err = 1'(err);
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("d0=%h d1=%h rs=%b err=%b", e.d0, e.d1, e.rs, e.err);
  endfunction

  function automatic exp_t observe();
    return {r0data_o, r1data_o, rsreserved_o, sb_err_o};
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst;
    r0num_i = s.r0n; r0valid_i = s.r0v; r1num_i = s.r1n; r1valid_i = s.r1v;
    rdnum_i = s.rdn; rdreserve_i = s.rdr;
    wb_valid_i = s.wbv; wb_num_i = s.wbn; wb_data_i = s.wbd;
  endtask

  task automatic do_reset();
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(st(0, 3, 1, 5, 1, 5, 1, 1, 6, 32'hFFFF_FFFF)); e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(0, 3, 1, 5, 1, 5, 1, 1, 6, 32'hFFFF_FFFF)); e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 5, 1, 6, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 5, 1, 6, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    // Writeback to an unreserved register updates data but flags the scoreboard.
    s.push_back(st(1, 5, 0, 0, 0, 0, 0, 1, 5, 32'h1234_5678)); e.push_back(ex(32'h1234_5678, 0, 0, 0));
    s.push_back(st(1, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0));         e.push_back(ex(32'h1234_5678, 0, 0, 1));
    s.push_back(st(1, 0, 0, 5, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 32'h1234_5678, 0, 1));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL write_read row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 0, 0, 7, 1, 7, 1, 0, 0, 32'h0));         e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 7, 1, 0, 0, 1, 7, 32'hA5A5_A5A5)); e.push_back(ex(0, 32'hA5A5_A5A5, 0, 0));
    s.push_back(st(1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 32'hA5A5_A5A5, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL raw row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 3, 1, 0, 0, 3, 1, 0, 0, 32'h0));  e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 3, 1, 0, 0, 3, 1, 0, 0, 32'h0));  e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 3, 1, 0, 0, 0, 0, 1, 3, 32'h11)); e.push_back(ex(32'h11, 0, 1, 0));
    s.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0));  e.push_back(ex(32'h11, 0, 1, 0));
    s.push_back(st(1, 3, 1, 0, 0, 0, 0, 1, 3, 32'h22)); e.push_back(ex(32'h22, 0, 0, 0));
    s.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0));  e.push_back(ex(32'h22, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL waw row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    // Reserve and writeback of x2 in one cycle must leave one writer pending.
    s.push_back(st(1, 0, 0, 2, 1, 2, 1, 0, 0, 32'h0));  e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 2, 1, 2, 1, 1, 2, 32'h33)); e.push_back(ex(0, 32'h33, 0, 0));
    s.push_back(st(1, 0, 0, 2, 1, 0, 0, 0, 0, 32'h0));  e.push_back(ex(0, 32'h33, 1, 0));
    s.push_back(st(1, 0, 0, 2, 1, 0, 0, 1, 2, 32'h44)); e.push_back(ex(0, 32'h44, 0, 0));
    s.push_back(st(1, 0, 0, 2, 1, 0, 0, 0, 0, 32'h0));  e.push_back(ex(0, 32'h44, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL back_to_back row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 0, 1, 0, 1, 0, 1, 1, 0, 32'hFFFF_FFFF)); e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0));         e.push_back(ex(0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL x0 row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 9, 1, 0, 0, 9, 1, 0, 0, 32'h0)); e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 9, 1, 0, 0, 9, 1, 0, 0, 32'h0)); e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 9, 1, 0, 0, 9, 1, 0, 0, 32'h0)); e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 9, 1, 0, 0, 9, 1, 0, 0, 32'h0)); e.push_back(ex(0, 0, 1, 0));
    s.push_back(st(1, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0)); e.push_back(ex(0, 0, 1, 1));
    s.push_back(st(1, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0)); e.push_back(ex(0, 0, 1, 1));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL overflow row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_underflow();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 1, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE)); e.push_back(ex(32'hCAFE, 0, 0, 0));
    s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));    e.push_back(ex(32'hCAFE, 0, 0, 1));
    s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));    e.push_back(ex(32'hCAFE, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL underflow row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    do_reset();
    s.push_back(st(1, 4, 1, 6, 1, 6, 1, 0, 0, 32'h0));    e.push_back(ex(0, 0, 0, 0));
    s.push_back(st(1, 4, 1, 6, 1, 4, 1, 1, 6, 32'hBEEF)); e.push_back(ex(0, 32'hBEEF, 0, 0));
    s.push_back(st(1, 4, 1, 6, 1, 0, 0, 0, 0, 32'h0));    e.push_back(ex(0, 32'hBEEF, 1, 0));
    foreach (s[i]) begin
      apply(s[i]); sb_q.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL async_reset row %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
    sb_q.push_back(ex(0, 32'hBEEF, 1, 0));
    got = observe(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL async_reset pre-assert: got %s, want %s", fmt(got), fmt(want));
    end
    #2 rst_n = 1'b0;
    sb_q.push_back(ex(0, 0, 0, 0));
    #1;
    got = observe(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL async_reset mid-cycle: got %s, want %s", fmt(got), fmt(want));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_back_to_back();
    test_x0();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
